circ_fifo: RTL and testbench
============================

# circ_fifo

Parametrised synchronous circular-queue FIFO, the successor to the fixed 16-entry × 16-bit queue. Width, depth and almost-full/almost-empty thresholds are parameters, and all DEPTH entries are usable. It adds an occupancy count, simultaneous read/write at the boundaries, a synchronous flush, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, in place of the fixed queue.

## Interface
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL (0..DEPTH-1)
- AW (derived), log2(DEPTH), address width; CW = AW+1 count width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; takes effect on the rising edge where it is sampled high
- wr  in  1  write request
- d_in  in  WIDTH  write data
- rd  in  1  read request
- flush  in  1  synchronous clear of queue contents
- clr_err  in  1  clears the sticky error flags
- d_out  out  WIDTH  registered read data
- rd_valid  out  1  d_out was loaded on the preceding edge
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected while full
- underflow  out  1  sticky: a read was rejected while empty

## Operation
- State: storage array of DEPTH×WIDTH, wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[CW-1:0], d_out, rd_valid, overflow, underflow. Storage is not reset.
- Status outputs are decoded from the registered count only, never from wr or rd.
- Write acceptance: wr_acc = wr & (~full | rd).
  - When accepted, d_in is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Read acceptance: rd_acc = rd & ~empty.
  - When accepted, d_out ← mem[rd_ptr] (the pre-edge contents), rd_ptr increments modulo DEPTH, and rd_valid ← 1.
  - Otherwise rd_valid ← 0 and d_out holds its value.
- Count update:
  - +1 on wr_acc & ~rd_acc
  - −1 on rd_acc & ~wr_acc
  - unchanged when both or neither are accepted
- Full with rd & wr: both are accepted and count stays DEPTH. The read returns the oldest entry. The write lands in the slot just vacated, since wr_ptr == rd_ptr.
- Empty with rd & wr: only the write is accepted and count becomes 1. Underflow is set and rd_valid = 0. There is no fall-through.
- Error flags:
  - overflow ← 1 on wr & full & ~rd.
  - underflow ← 1 on rd & empty.
  - Both flags hold until clr_err or reset. If clr_err and a new error occur in the same cycle, the set wins.
- Pointer wrap: DEPTH-1 → 0. The count, not the pointers, distinguishes full from empty.
- Priority: reset > flush > normal operation.
  - flush sets wr_ptr, rd_ptr and count to 0 and rd_valid to 0.
  - flush does not change d_out or the error flags.
  - wr and rd are ignored in a flush cycle.
- Reset values:
  - count = 0
  - pointers = 0
  - d_out = 0
  - rd_valid = 0
  - overflow = underflow = 0
  - outputs therefore read empty = 1, full = 0, almost_empty = 1, almost_full = 0 (AF_LEVEL ≥ 1)
- Reset mid-operation: every register above returns to its reset value on that edge. Any wr or rd in the same cycle is discarded.

## Timing
- Write-to-read latency: data written on edge N is readable by a rd sampled for edge N+1, and appears on d_out after edge N+1. empty deasserts after edge N.
- Read latency: one cycle. A rd accepted at edge N gives d_out/rd_valid valid from edge N until edge N+1.
- Status outputs update on the same edge as the pointer and count change, with no extra pipeline stage.
- Throughput: one write and one read per cycle, sustained, in every state.
- No combinational path from any input to any output.

## Test plan
- Reset, then fill: hold reset 2 cycles, then write 0x0001..0x0010 on 16 consecutive cycles → count reaches 16, full = 1 after the 16th edge, almost_full = 1 from count 14, empty = 0 after the first edge.
- Overflow and drain: with the queue full, write 0xDEAD with no rd → data dropped, overflow = 1, count stays 16. Then 16 reads → d_out sequence 0x0001..0x0010 with rd_valid = 1 each cycle, then empty = 1. One more rd → underflow = 1, rd_valid = 0, d_out holds 0x0010.
- Wrap-around: write 10 words, read 10, then write 12 words 0x0100..0x010B and read 12 → data returned in order across the pointer wrap 15→0, and count returns to 0.
- Simultaneous events:
  - full + rd & wr of 0xBEEF → oldest word read out, count stays 16, 0xBEEF is returned last.
  - empty + rd & wr of 0x1234 → count = 1, underflow = 1, next rd returns 0x1234.
- Flush and reset mid-operation:
  - with 5 entries, assert flush together with wr → count = 0, empty = 1, d_out unchanged, error flags unchanged.
  - refill 3 words and assert reset together with rd → count = 0, d_out = 0, rd_valid = 0, errors cleared.
- Parameter sweep: rerun the fill, drain and wrap scenarios with WIDTH = 8, DEPTH = 4 (AF_LEVEL = 3, AE_LEVEL = 1) and WIDTH = 32, DEPTH = 64 → all ordering and flag checks hold against a reference queue model.

Source files
------------

// File: rtl/circ_fifo.sv
// Parametrised synchronous circular-queue FIFO with occupancy count, flush,
// registered status flags and sticky overflow/underflow error flags.
module circ_fifo #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] d_in,
    input  logic             rd,
    input  logic             flush,
    input  logic             clr_err,
    output logic [WIDTH-1:0] d_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_en;
    logic          rd_en;
    logic          overflow_nxt;
    logic          underflow_nxt;

    // Acceptance, pointer/count and error-flag next state
    always_comb begin
        wr_acc        = wr & (~full | rd);
        rd_acc        = rd & ~empty;
        wr_en         = wr_acc & ~flush;
        rd_en         = rd_acc & ~flush;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        count_nxt     = count;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;

        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (wr_en) wr_ptr_nxt = wr_ptr + AW'(1);
            if (rd_en) rd_ptr_nxt = rd_ptr + AW'(1);
            if (wr_en && !rd_en) count_nxt = count + CW'(1);
            if (rd_en && !wr_en) count_nxt = count - CW'(1);
        end

        // A new error in the same cycle as clr_err wins over the clear
        if (clr_err) begin
            overflow_nxt  = 1'b0;
            underflow_nxt = 1'b0;
        end
        if (!flush && wr && full && !rd) overflow_nxt  = 1'b1;
        if (!flush && rd && empty)       underflow_nxt = 1'b1;
    end

    // Control, status and read-data registers; status flags follow count_nxt
    // so they change on the same edge as the count they decode
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            d_out        <= '0;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            rd_valid     <= rd_en;
            overflow     <= overflow_nxt;
            underflow    <= underflow_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
            if (rd_en) d_out <= mem[rd_ptr];
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_ptr] <= d_in;
    end

endmodule

// File: tb/tb_circ_fifo.sv
// Directed self-checking bench for circ_fifo: default 16x16 instance plus a
// small 4x8 instance checked against a reference queue model.
module tb_circ_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr, rd, flush, clr_err;
    logic [15:0] d_in, d_out;
    logic        rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0]  count;
    logic        overflow, underflow;

    logic       b_wr, b_rd, b_flush, b_clr_err;
    logic [7:0] b_d_in, b_d_out;
    logic       b_rd_valid, b_full, b_empty, b_af, b_ae;
    logic [2:0] b_count;
    logic       b_overflow, b_underflow;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [7:0]  q [$];
    logic [7:0]  exp8;

    always #5 clk = ~clk;

    circ_fifo dut (
        .clk(clk), .reset(reset), .wr(wr), .d_in(d_in), .rd(rd),
        .flush(flush), .clr_err(clr_err), .d_out(d_out), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    circ_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
        .clk(clk), .reset(reset), .wr(b_wr), .d_in(b_d_in), .rd(b_rd),
        .flush(b_flush), .clr_err(b_clr_err), .d_out(b_d_out),
        .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; wr = 0; rd = 0; flush = 0; clr_err = 0; d_in = '0;
        b_wr = 0; b_rd = 0; b_flush = 0; b_clr_err = 0; b_d_in = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_count", 64'(count), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);
        chk("rst_ae", 64'(almost_empty), 1);
        chk("rst_af", 64'(almost_full), 0);
        chk("rst_dout", 64'(d_out), 0);
        chk("rst_rdv", 64'(rd_valid), 0);
        chk("rst_err", 64'({overflow, underflow}), 0);

        // Fill 0x0001..0x0010
        wr = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            d_in = 16'(i);
            step();
            chk("fill_count", 64'(count), 64'(i));
            chk("fill_empty", 64'(empty), 0);
            chk("fill_full", 64'(full), 64'(i == 16));
            chk("fill_af", 64'(almost_full), 64'(i >= 14));
            chk("fill_ae", 64'(almost_empty), 64'(i <= 2));
        end

        // Write while full is dropped
        d_in = 16'hDEAD;
        step();
        wr = 1'b0;
        chk("ovf_flag", 64'(overflow), 1);
        chk("ovf_count", 64'(count), 16);

        // Drain in order, then one read too many
        rd = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("drain_dout", 64'(d_out), 64'(i));
            chk("drain_rdv", 64'(rd_valid), 1);
            chk("drain_count", 64'(count), 64'(16 - i));
        end
        chk("drain_empty", 64'(empty), 1);
        step();
        rd = 1'b0;
        chk("unf_flag", 64'(underflow), 1);
        chk("unf_rdv", 64'(rd_valid), 0);
        chk("unf_dout", 64'(d_out), 16'h0010);

        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_err", 64'({overflow, underflow}), 0);

        // Wrap-around: 10 in/out then 12 across the 15->0 boundary
        wr = 1'b1;
        for (int i = 0; i < 10; i++) begin d_in = 16'h0200 + 16'(i); step(); end
        wr = 1'b0;
        chk("wrap_count10", 64'(count), 10);
        rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("wrap_dout_a", 64'(d_out), 64'(16'h0200 + 16'(i)));
        end
        rd = 1'b0;
        wr = 1'b1;
        for (int i = 0; i < 12; i++) begin d_in = 16'h0100 + 16'(i); step(); end
        wr = 1'b0;
        rd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("wrap_dout_b", 64'(d_out), 64'(16'h0100 + 16'(i)));
        end
        rd = 1'b0;
        chk("wrap_count0", 64'(count), 0);

        // Full with simultaneous rd & wr
        wr = 1'b1;
        for (int i = 0; i < 16; i++) begin d_in = 16'h0300 + 16'(i); step(); end
        rd = 1'b1; d_in = 16'hBEEF;
        step();
        wr = 1'b0;
        chk("fullrw_dout", 64'(d_out), 16'h0300);
        chk("fullrw_count", 64'(count), 16);
        chk("fullrw_ovf", 64'(overflow), 0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("fullrw_drain", 64'(d_out), 64'(16'h0300 + 16'(i)));
        end
        step();
        chk("fullrw_last", 64'(d_out), 16'hBEEF);
        chk("fullrw_empty", 64'(empty), 1);

        // Empty with simultaneous rd & wr: no fall-through
        wr = 1'b1; d_in = 16'h1234;
        step();
        wr = 1'b0;
        chk("emptyrw_count", 64'(count), 1);
        chk("emptyrw_unf", 64'(underflow), 1);
        chk("emptyrw_rdv", 64'(rd_valid), 0);
        chk("emptyrw_hold", 64'(d_out), 16'hBEEF);
        step();
        rd = 1'b0;
        chk("emptyrw_read", 64'(d_out), 16'h1234);
        chk("emptyrw_rdv2", 64'(rd_valid), 1);

        // Flush with 5 entries and a concurrent write
        wr = 1'b1;
        for (int i = 0; i < 5; i++) begin d_in = 16'h0400 + 16'(i); step(); end
        flush = 1'b1; d_in = 16'h5555;
        step();
        flush = 1'b0; wr = 1'b0;
        chk("flush_count", 64'(count), 0);
        chk("flush_empty", 64'(empty), 1);
        chk("flush_dout", 64'(d_out), 16'h1234);
        chk("flush_err", 64'({overflow, underflow}), 64'(2'b01));

        // Refill 3, then reset with a concurrent read
        wr = 1'b1;
        for (int i = 0; i < 3; i++) begin d_in = 16'h0500 + 16'(i); step(); end
        wr = 1'b0;
        chk("refill_dout", 64'(d_out), 16'h1234);
        reset = 1'b1; rd = 1'b1;
        step();
        reset = 1'b0; rd = 1'b0;
        chk("midrst_count", 64'(count), 0);
        chk("midrst_dout", 64'(d_out), 0);
        chk("midrst_rdv", 64'(rd_valid), 0);
        chk("midrst_err", 64'({overflow, underflow}), 0);
        wr = 1'b1; d_in = 16'h0077;
        step();
        wr = 1'b0; rd = 1'b1;
        step();
        rd = 1'b0;
        chk("postrst_read", 64'(d_out), 16'h0077);

        // Small instance: fill, overflow, sustained rd&wr across wraps, drain
        b_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_d_in = 8'hA1 + 8'(i);
            q.push_back(b_d_in);
            step();
            chk("b_fill_count", 64'(b_count), 64'(i + 1));
            chk("b_fill_full", 64'(b_full), 64'(i == 3));
            chk("b_fill_af", 64'(b_af), 64'(i + 1 >= 3));
            chk("b_fill_ae", 64'(b_ae), 64'(i + 1 <= 1));
        end
        b_d_in = 8'hEE;
        step();
        chk("b_ovf", 64'(b_overflow), 1);
        chk("b_ovf_count", 64'(b_count), 4);
        b_rd = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b_d_in = 8'hC0 + 8'(k);
            exp8 = q.pop_front();
            q.push_back(b_d_in);
            step();
            chk("b_rw_dout", 64'(b_d_out), 64'(exp8));
            chk("b_rw_count", 64'(b_count), 4);
        end
        b_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp8 = q.pop_front();
            step();
            chk("b_drain_dout", 64'(b_d_out), 64'(exp8));
            chk("b_drain_count", 64'(b_count), 64'(3 - k));
        end
        chk("b_empty", 64'(b_empty), 1);
        step();
        b_rd = 1'b0;
        chk("b_unf", 64'(b_underflow), 1);
        chk("b_unf_hold", 64'(b_d_out), 64'(exp8));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
